// File: rtl/pkt_pack_pkg.sv
// Shared definitions for the pixel word packer: FSM encoding and default
// parameter values.
package pkt_pack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_IN_W      = 32;
  localparam int DEF_RATIO     = 3;
  localparam int DEF_MSB_FIRST = 1;
  localparam int DEF_REQ_EDGE  = 0;
  localparam int DEF_TIMEOUT   = 255;

endpackage

// File: rtl/req_edge_det.sv
// Request edge detector: two-flop register of req, single-cycle trig on the
// selected edge. A req already sitting at its post-trigger level after reset
// is ignored until it has been seen at the pre-trigger level (armed).
module req_edge_det
  import pkt_pack_pkg::*;
#(
  parameter int REQ_EDGE = DEF_REQ_EDGE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic trig
);

  // Level req must show before an edge counts (1 before a fall, 0 before a rise).
  localparam logic PRE_LVL = (REQ_EDGE == 0) ? 1'b1 : 1'b0;

  logic r0;
  logic r1;
  logic v0;
  logic armed;
  logic edge_raw;

  // Register req twice; v0 marks that r0 holds a real sample, armed marks
  // that the pre-trigger level has been observed since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0    <= 1'b0;
      r1    <= 1'b0;
      v0    <= 1'b0;
      armed <= 1'b0;
    end else begin
      r0    <= req;
      r1    <= r0;
      v0    <= 1'b1;
      armed <= armed | (v0 & (r0 == PRE_LVL));
    end
  end

  assign edge_raw = (REQ_EDGE == 0) ? (r1 & ~r0) : (~r1 & r0);
  assign trig     = armed & edge_raw;

endmodule

// File: rtl/pixel_word_packer.sv
// Pixel word packer: on a req edge, reads RATIO words from an upstream FIFO
// and presents them concatenated as one wide word.
//
// Handshake: fifo_rd is a read strobe; fifo_rdata is valid the cycle after
// each fifo_rd. Reads are never issued while fifo_empty is high. out_valid is
// a one-cycle pulse with no back-pressure; out_data holds until the next
// pulse; underrun qualifies the pulse when the word was finished by timeout.
module pixel_word_packer
  import pkt_pack_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int RATIO     = DEF_RATIO,
  parameter int MSB_FIRST = DEF_MSB_FIRST,
  parameter int REQ_EDGE  = DEF_REQ_EDGE,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd,
  input  logic [IN_W-1:0]       fifo_rdata,
  input  logic                  fifo_empty,
  input  logic                  req,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic                  out_valid,
  output logic                  underrun,
  output logic                  overrun,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int PW    = $clog2(OUT_W);

  state_t         state;
  logic           trig;
  logic           pending;
  logic           timed_out;
  logic           rd_d;
  logic [CW-1:0]  rd_cnt;
  logic [CW-1:0]  cap_cnt;
  logic [TW-1:0]  stall_cnt;
  logic [OUT_W-1:0] shreg;
  logic [OUT_W-1:0] shreg_next;
  logic           cap_en;
  logic [PW-1:0]  cap_pos;
  logic           stalling;
  logic           last_read;
  logic           timeout_hit;
  int             slot;

  req_edge_det #(.REQ_EDGE(REQ_EDGE)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .trig  (trig)
  );

  assign fifo_rd     = (state == ST_READ) & ~fifo_empty & (rd_cnt < CW'(RATIO));
  assign stalling    = (state == ST_READ) & fifo_empty & (rd_cnt < CW'(RATIO));
  assign last_read   = fifo_rd & (rd_cnt == CW'(RATIO - 1));
  assign timeout_hit = stalling & (stall_cnt == TW'(TIMEOUT - 1));
  assign cap_en      = rd_d & (cap_cnt < CW'(RATIO));
  assign dbg_state   = state;

  // Slot placement of the next captured word; first-read word goes on top
  // when MSB_FIRST is set, otherwise at the bottom.
  always_comb begin
    slot       = 0;
    cap_pos    = '0;
    shreg_next = shreg;
    if (cap_en) begin
      slot       = (MSB_FIRST != 0) ? (RATIO - 1 - int'(cap_cnt)) : int'(cap_cnt);
      cap_pos    = PW'(slot * IN_W);
      shreg_next[cap_pos +: IN_W] = fifo_rdata;
    end
  end

  // Control FSM with counters, request queueing and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pending   <= 1'b0;
      timed_out <= 1'b0;
      rd_d      <= 1'b0;
      rd_cnt    <= '0;
      cap_cnt   <= '0;
      stall_cnt <= '0;
      shreg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      rd_d      <= fifo_rd;
      shreg     <= shreg_next;
      if (cap_en) cap_cnt <= cap_cnt + CW'(1);

      // One request may wait while busy; a further one is dropped.
      if (state == ST_IDLE) begin
        if (pending) pending <= trig;
      end else if (trig) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (trig || pending) begin
            state     <= ST_READ;
            busy      <= 1'b1;
            rd_cnt    <= '0;
            cap_cnt   <= '0;
            stall_cnt <= '0;
            shreg     <= '0;
            timed_out <= 1'b0;
          end
        end
        ST_READ: begin
          if (fifo_rd) begin
            rd_cnt    <= rd_cnt + CW'(1);
            stall_cnt <= '0;
          end else if (stalling) begin
            stall_cnt <= stall_cnt + TW'(1);
          end
          if (last_read) begin
            state <= ST_DRAIN;
          end else if (timeout_hit) begin
            state     <= ST_DRAIN;
            timed_out <= 1'b1;
          end
        end
        ST_DRAIN: begin
          state     <= ST_DONE;
          out_valid <= 1'b1;
          out_data  <= shreg_next;
          underrun  <= timed_out;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Bench for pixel_word_packer: two instances (top-first and bottom-first
// packing) share one FIFO model and req; expected words are queued by the
// stimulus and consumed by a monitor whenever out_valid appears.
module tb_pixel_word_packer;
  import pkt_pack_pkg::*;

  localparam int W  = 32;
  localparam int R  = 3;
  localparam int OW = W * R;

  typedef struct {
    logic [OW-1:0] data_a;
    logic [OW-1:0] data_b;
    logic          under;
    int            cyc;
    int            reads;
    int            ovr;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          req;
  logic          fifo_rd_a, fifo_rd_b;
  logic [W-1:0]  fifo_rdata;
  logic          fifo_empty;
  logic [OW-1:0] out_data_a, out_data_b;
  logic          out_valid_a, out_valid_b;
  logic          underrun_a, underrun_b;
  logic          overrun_a, overrun_b;
  logic          busy_a, busy_b;
  state_t        dbg_a, dbg_b;

  pixel_word_packer #(.IN_W(W), .RATIO(R), .MSB_FIRST(1), .REQ_EDGE(0), .TIMEOUT(8)) u_msb (
    .clk(clk), .rst_n(rst_n), .fifo_rd(fifo_rd_a), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .req(req), .out_data(out_data_a), .out_valid(out_valid_a),
    .underrun(underrun_a), .overrun(overrun_a), .busy(busy_a), .dbg_state(dbg_a)
  );

  pixel_word_packer #(.IN_W(W), .RATIO(R), .MSB_FIRST(0), .REQ_EDGE(0), .TIMEOUT(8)) u_lsb (
    .clk(clk), .rst_n(rst_n), .fifo_rd(fifo_rd_b), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .req(req), .out_data(out_data_b), .out_valid(out_valid_b),
    .underrun(underrun_b), .overrun(overrun_b), .busy(busy_b), .dbg_state(dbg_b)
  );

  // ---------------- FIFO model ----------------
  logic [W-1:0] fifo_mem [0:63];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  logic         fifo_block;

  assign fifo_empty = (rd_ptr == wr_ptr) || fifo_block;

  always @(posedge clk) begin
    if (fifo_rd_a && (rd_ptr != wr_ptr)) begin
      fifo_rdata <= fifo_mem[rd_ptr[5:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_seen  = 0;
  int   ovr_seen = 0;

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_out_data_a", out_data_a, '0);
      chk("rst_out_data_b", out_data_b, '0);
      chk("rst_out_valid", OW'({out_valid_a, out_valid_b}), '0);
      chk("rst_underrun", OW'({underrun_a, underrun_b}), '0);
      chk("rst_overrun", OW'({overrun_a, overrun_b}), '0);
      chk("rst_busy", OW'({busy_a, busy_b}), '0);
      chk("rst_fifo_rd", OW'({fifo_rd_a, fifo_rd_b}), '0);
      chk("rst_state", OW'({dbg_a, dbg_b}), OW'({ST_IDLE, ST_IDLE}));
      rd_seen  = 0;
      ovr_seen = 0;
    end else begin
      if (fifo_rd_a) rd_seen++;
      if (overrun_a) ovr_seen++;
      if (fifo_empty) chk("rd_while_empty", OW'(fifo_rd_a), '0);
      if (fifo_rd_a || fifo_rd_b) chk("rd_match", OW'(fifo_rd_b), OW'(fifo_rd_a));
      if (out_valid_a || out_valid_b) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", OW'({out_valid_a, out_valid_b}), '0);
        end else begin
          e = exp_q.pop_front();
          chk("valid_pair", OW'({out_valid_a, out_valid_b}), OW'(2'b11));
          chk("valid_cycle", OW'(cyc), OW'(e.cyc));
          chk("data_msb", out_data_a, e.data_a);
          chk("data_lsb", out_data_b, e.data_b);
          chk("underrun", OW'({underrun_a, underrun_b}), OW'({e.under, e.under}));
          chk("read_count", OW'(rd_seen), OW'(e.reads));
          chk("overrun_count", OW'(ovr_seen), OW'(e.ovr));
          rd_seen  = 0;
          ovr_seen = 0;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        e = exp_q.pop_front();
        chk("missing_valid", OW'(0), OW'(1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_word(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                             input logic under, input int at, input int reads, input int ovr);
    exp_t e;
    e.data_a = {w0, w1, w2};
    e.data_b = {w2, w1, w0};
    e.under  = under;
    e.cyc    = at;
    e.reads  = reads;
    e.ovr    = ovr;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) step(1);
    step(2);
  endtask

  // ---------------- stimulus ----------------
  int t;

  initial begin
    rst_n      = 1'b0;
    req        = 1'b1;
    fifo_block = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(3);

    // Normal transfer: out_data 0x111111112222222233333333, valid at T+5.
    push(32'h11111111); push(32'h22222222); push(32'h33333333);
    req = 1'b0; t = cyc + 1;
    expect_word(32'h11111111, 32'h22222222, 32'h33333333, 1'b0, t + 5, 3, 0);
    wait_drain();
    req = 1'b1; step(2);

    // Stall of 4 cycles after the first read: valid at T+9, no underrun.
    push(32'h12345678); push(32'h9abcdef0); push(32'h0f1e2d3c);
    req = 1'b0; t = cyc + 1;
    expect_word(32'h12345678, 32'h9abcdef0, 32'h0f1e2d3c, 1'b0, t + 9, 3, 0);
    step(3); fifo_block = 1'b1;
    step(4); fifo_block = 1'b0;
    wait_drain();
    req = 1'b1; step(2);

    // Timeout with a single word: zero fill, underrun, valid at T+11.
    push(32'haaaaaaaa);
    req = 1'b0; t = cyc + 1;
    expect_word(32'haaaaaaaa, 32'h0, 32'h0, 1'b1, t + 11, 1, 0);
    wait_drain();
    req = 1'b1; step(2);

    // Three trigs in one transfer: one queued, one dropped (overrun at T+5).
    push(32'hb0000001); push(32'hb0000002); push(32'hb0000003);
    push(32'hc0000001); push(32'hc0000002); push(32'hc0000003);
    req = 1'b0; t = cyc + 1;
    expect_word(32'hb0000001, 32'hb0000002, 32'hb0000003, 1'b0, t + 5, 3, 1);
    expect_word(32'hc0000001, 32'hc0000002, 32'hc0000003, 1'b0, t + 11, 3, 0);
    step(1); req = 1'b1;
    step(1); req = 1'b0;
    step(1); req = 1'b1;
    step(1); req = 1'b0;
    wait_drain();
    req = 1'b1; step(2);

    // Trig landing on the DONE cycle: queued and started without loss.
    push(32'hd0000001); push(32'hd0000002); push(32'hd0000003);
    push(32'he0000001); push(32'he0000002); push(32'he0000003);
    req = 1'b0; t = cyc + 1;
    expect_word(32'hd0000001, 32'hd0000002, 32'hd0000003, 1'b0, t + 5, 3, 0);
    expect_word(32'he0000001, 32'he0000002, 32'he0000003, 1'b0, t + 11, 3, 0);
    step(1); req = 1'b1;
    step(4); req = 1'b0;
    wait_drain();
    req = 1'b1; step(2);

    // Reset after two reads: transfer abandoned, no valid until a new edge.
    push(32'h44444444); push(32'h55555555); push(32'h66666666);
    req = 1'b0;
    step(4);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(12);
    push(32'h77777777); push(32'h88888888);
    req = 1'b1; step(2);
    req = 1'b0; t = cyc + 1;
    expect_word(32'h66666666, 32'h77777777, 32'h88888888, 1'b0, t + 5, 3, 0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_word_packer.md
PIXEL_WORD_PACKER -- requirements
Module: pixel_word_packer

Interface
REQ-001 SHALL have parameter IN_W, default 32, meaning the FIFO read word width in bits.
REQ-002 SHALL have parameter RATIO, default 3, range 2..16, meaning the number of FIFO words packed per output word.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 places the first-read word in the top bits; 0 places it in the bottom bits.
REQ-004 SHALL have parameter REQ_EDGE, default 0: 0 triggers on a falling edge of req; 1 triggers on a rising edge.
REQ-005 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of consecutive stall cycles while fifo_empty is high.
REQ-006 SHALL use clock clk, input, 1 bit, rising-edge.
REQ-007 SHALL use reset rst_n, input, 1 bit, asynchronous, active-low.
REQ-008 SHALL have fifo_rd, output, 1 bit, read strobe to the upstream FIFO.
REQ-009 SHALL have fifo_rdata, input, IN_W bits, FIFO data, valid one cycle after fifo_rd.
REQ-010 SHALL have fifo_empty, input, 1 bit, FIFO-empty flag.
REQ-011 SHALL have req, input, 1 bit, consumer read-request level.
REQ-012 SHALL have out_data, output, IN_W*RATIO bits, the packed word.
REQ-013 SHALL have out_valid, output, 1 bit, one-cycle pulse when out_data updates.
REQ-014 SHALL have underrun, output, 1 bit, qualifies out_valid: the word was completed by timeout.
REQ-015 SHALL have overrun, output, 1 bit, one-cycle pulse when a request is dropped.
REQ-016 SHALL have busy, output, 1 bit, high in every state except IDLE.

Function
REQ-017 SHALL register req through two flops (r0, r1); trig SHALL be r1&~r0 when REQ_EDGE=0 and ~r1&r0 when REQ_EDGE=1.
REQ-018 SHALL implement FSM IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE to READ on trig or pending.
- READ to DRAIN when rd_cnt reaches RATIO or on timeout.
- DRAIN to DONE after one cycle.
- DONE to IDLE after one cycle.
REQ-019 SHALL drive fifo_rd combinationally as (state==READ) & ~fifo_empty & (rd_cnt<RATIO); fifo_rd SHALL never be high while fifo_empty is high.
REQ-020 SHALL capture fifo_rdata into a shift register in every cycle following a fifo_rd cycle, including in DRAIN.
REQ-021 SHALL place the k-th captured word (k=0..RATIO-1):
- at bits [(RATIO-k)*IN_W-1 -: IN_W] when MSB_FIRST=1;
- at bits [(k+1)*IN_W-1 -: IN_W] when MSB_FIRST=0.
REQ-022 SHALL load out_data and pulse out_valid in DONE; out_data SHALL hold its value until the next DONE.
REQ-023 SHALL give a latency, with the FIFO never empty, from the trig cycle T of: reads at T+1..T+RATIO and out_valid at T+RATIO+2.
REQ-024 SHALL stall on fifo_empty in READ and count the stalled cycles; the stall count SHALL clear on each fifo_rd.
REQ-025 SHALL, when the stall count reaches TIMEOUT, leave READ, zero-fill the missing words, and assert underrun together with out_valid.
REQ-026 SHALL latch one pending request when trig occurs while busy; a trig while pending is already set SHALL pulse overrun and be dropped.
REQ-027 SHALL, when trig and the DONE->IDLE transition coincide, latch the request as pending and start it from IDLE on the next cycle, with no loss.
REQ-028 SHALL clear rd_cnt, the capture count, the stall count and the shift register on entry to READ.

Reset
REQ-029 SHALL, while rst_n is low, set the state to IDLE and set r0, r1, pending, all counters, out_data, out_valid, underrun, overrun and busy to 0; fifo_rd is therefore 0.
REQ-030 SHALL, on reset asserted mid-transfer, abandon the transfer with no out_valid and no further fifo_rd.
REQ-031 SHALL, after reset release, ignore a req already held at its post-trigger level until a genuine edge occurs.

Structure
REQ-032 SHALL define the FSM state encoding and the default parameter constants in a shared package, pkt_pack_pkg.
REQ-033 SHALL place the edge detector in sub-module req_edge_det, with parameter REQ_EDGE, inputs clk, rst_n, req, and output trig.

Verification
REQ-034 SHALL cover the default-parameter normal case: FIFO holding 0x11111111, 0x22222222, 0x33333333 and a falling edge on req -> exactly 3 fifo_rd, out_valid at T+5, out_data = 0x111111112222222233333333.
REQ-035 SHALL cover MSB_FIRST=0 with the same data -> out_data = 0x333333332222222211111111.
REQ-036 SHALL cover a stall: FIFO empty for 4 cycles after the first read -> fifo_rd stays low during the stall, out_valid at T+9, underrun=0.
REQ-037 SHALL cover timeout with TIMEOUT=8 and only one word 0xAAAAAAAA available -> out_valid with underrun=1 and out_data = 0xAAAAAAAA0000000000000000.
REQ-038 SHALL cover back-to-back requests: 3 trig events during one transfer -> 1 overrun pulse and 2 out_valid pulses in total.
REQ-039 SHALL cover reset mid-transfer: rst_n low after 2 reads -> all outputs 0, and no out_valid until a new edge.
